// File: rtl/pdm_decoder.sv
// pdm_decoder: 1-bit PDM to unsigned NBITS amplitude via 3rd-order CIC, decimation 2^LOG2_R.
// Rev 1.0
`default_nettype none

module pdm_decoder #(
  parameter int NBITS  = 24,
  parameter int LOG2_R = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  output logic [NBITS-1:0] dout,
  output logic             valid
);

  localparam int P = 3 * LOG2_R;
  localparam int W = P + 1;

  logic [W-1:0]      i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [W-1:0]      d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
  logic [LOG2_R-1:0] cnt_q, cnt_d;
  logic              dec_q, dec_d;
  logic [NBITS-1:0]  dout_q, dout_d;
  logic              valid_q, valid_d;

  logic [W-1:0]      c1, c2, c3;
  logic [P-1:0]      sat;
  logic [NBITS-1:0]  scaled;

  assign c1  = i3_q - d1_q;
  assign c2  = c1 - d2_q;
  assign c3  = c2 - d3_q;
  // c3 never exceeds 2^P, so its top bit alone flags the single overflow value
  assign sat = c3[P] ? {P{1'b1}} : c3[P-1:0];

  generate
    if (P >= NBITS) begin : g_shr
      assign scaled = sat[P-1 -: NBITS];
    end else begin : g_shl
      assign scaled = {sat, {(NBITS-P){1'b0}}};
    end
  endgenerate

  always_comb begin
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    cnt_d   = cnt_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    dout_d  = dout_q;
    dec_d   = enable && (&cnt_q);
    valid_d = dec_q;
    if (enable) begin
      i1_d  = i1_q + W'(din);
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + LOG2_R'(1);
    end
    if (dec_q) begin
      d1_d   = i3_q;
      d2_d   = c1;
      d3_d   = c2;
      dout_d = scaled;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_decoder.sv
// tb_pdm_decoder: directed checks of pdm_decoder with default parameters (R = 256).
`default_nettype none

module tb_pdm_decoder;

  localparam int NBITS  = 24;
  localparam int LOG2_R = 8;
  localparam int R      = 256;

  logic             clock  = 1'b0;
  logic             reset  = 1'b0;
  logic             enable = 1'b0;
  logic             din    = 1'b0;
  logic [NBITS-1:0] dout;
  logic             valid;

  pdm_decoder #(.NBITS(NBITS), .LOG2_R(LOG2_R)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .din    (din),
    .dout   (dout),
    .valid  (valid)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // stimulus state: mode 0 zeros, 1 ones, 2 alternating 1/0, 3 first-order modulator at 0x400000
  int          mode   = 0;
  int          en_div = 1;
  int          phase  = 0;
  int          sidx   = 0;
  logic [23:0] acc    = '0;

  int          edges = 0;
  int          vcnt = 0;
  int          adjacent = 0;
  int          prebad = 0;
  logic        prev_valid = 1'b0;
  int          vtime [16];
  logic [23:0] vdata [16];

  // Hand-derived all-ones response: C(R,3), C(2R,3)-3C(R,3), then 2^24 saturated
  function automatic logic [23:0] ones_exp(input int j);
    if (j == 0)      return 24'h2A2B00;
    else if (j == 1) return 24'hD4D500;
    else             return 24'hFFFFFF;
  endfunction

  task automatic drive_next();
    logic [24:0] sum;
    enable = ((phase % en_div) == 0);
    din    = 1'b0;
    if (enable) begin
      case (mode)
        1: din = 1'b1;
        2: din = ((sidx % 2) == 0);
        3: begin
          sum = {1'b0, acc} + 25'h0400000;
          acc = sum[23:0];
          din = sum[24];
        end
        default: din = 1'b0;
      endcase
      sidx++;
    end
    phase++;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    edges++;
    if (valid === 1'b1) begin
      if (vcnt < 16) begin
        vtime[vcnt] = edges + 1;
        vdata[vcnt] = dout;
      end
      vcnt++;
      if (prev_valid) adjacent++;
    end else if (vcnt == 0 && dout !== '0) begin
      prebad++;
    end
    prev_valid = valid;
    drive_next();
  endtask

  task automatic hold_reset(input int n);
    reset  = 1'b0;
    enable = 1'b0;
    din    = 1'b0;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic release_rst();
    reset      = 1'b1;
    edges      = 0;
    vcnt       = 0;
    adjacent   = 0;
    prebad     = 0;
    prev_valid = 1'b0;
    phase      = 0;
    sidx       = 0;
    acc        = '0;
    drive_next();
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    while (vcnt < n && edges < bound) tick();
    check_eq({tag, " nvalid"}, (vcnt >= n), 1);
  endtask

  initial begin
    // Reset and zero input
    mode = 0; en_div = 1;
    hold_reset(2);
    check_eq("rst valid", valid, 0);
    check_eq("rst dout", dout, 0);
    hold_reset(3);
    check_eq("rst valid end", valid, 0);
    release_rst();
    run_until(3, 4 * R, "zeros");
    if (vcnt >= 3) begin
      check_eq("zeros first cycle", vtime[0], 258);
      for (int i = 0; i < 3; i++) check_eq("zeros dout", vdata[i], 0);
      check_eq("zeros period", vtime[2] - vtime[1], R);
    end

    // All ones
    hold_reset(2);
    mode = 1; en_div = 1;
    release_rst();
    run_until(7, 8 * R, "ones");
    if (vcnt >= 7) begin
      for (int i = 0; i < 7; i++) check_eq($sformatf("ones dout%0d", i), vdata[i], ones_exp(i));
      check_eq("ones period a", vtime[5] - vtime[4], R);
      check_eq("ones period b", vtime[6] - vtime[5], R);
    end
    check_eq("ones adjacent", adjacent, 0);

    // Half scale
    hold_reset(2);
    mode = 2; en_div = 1;
    release_rst();
    run_until(7, 8 * R, "half");
    if (vcnt >= 7)
      for (int i = 4; i < 7; i++) check_eq($sformatf("half dout%0d", i), vdata[i], 24'h800000);

    // Modulator loop-back: period-4 bit pattern divides R, so the steady state is exact
    hold_reset(2);
    mode = 3; en_div = 1;
    release_rst();
    run_until(7, 8 * R, "loop");
    if (vcnt >= 7)
      for (int i = 4; i < 7; i++) check_eq($sformatf("loop dout%0d", i), vdata[i], 24'h400000);

    // Enable gaps: 1 cycle in 3
    hold_reset(2);
    mode = 1; en_div = 3;
    release_rst();
    run_until(7, 8 * 3 * R, "gaps");
    if (vcnt >= 7) begin
      check_eq("gaps first cycle", vtime[0], 3 * R);
      for (int i = 0; i < 7; i++) check_eq($sformatf("gaps dout%0d", i), vdata[i], ones_exp(i));
      check_eq("gaps period", vtime[6] - vtime[5], 3 * R);
    end

    // Reset at cnt = 100 in the second window (dout already non-zero)
    hold_reset(2);
    mode = 1; en_div = 1;
    release_rst();
    repeat (R + 100) tick();
    check_eq("mid pre dout", dout, 24'h2A2B00);
    reset = 1'b0;
    #1;
    check_eq("mid rst dout", dout, 0);
    check_eq("mid rst valid", valid, 0);
    @(posedge clock);
    @(negedge clock);
    release_rst();
    run_until(1, 2 * R, "mid");
    check_eq("mid dout held zero", prebad, 0);
    if (vcnt >= 1) begin
      check_eq("mid first cycle", vtime[0], 258);
      check_eq("mid first dout", vdata[0], 24'h2A2B00);
    end

    // Reset during the dec cycle
    hold_reset(2);
    release_rst();
    repeat (R) tick();
    reset = 1'b0;
    #1;
    check_eq("dec rst valid", valid, 0);
    @(posedge clock);
    @(negedge clock);
    check_eq("dec rst valid next", valid, 0);
    check_eq("dec rst dout", dout, 0);
    release_rst();
    run_until(1, 2 * R, "dec");
    check_eq("dec dout held zero", prebad, 0);
    if (vcnt >= 1) begin
      check_eq("dec first cycle", vtime[0], 258);
      check_eq("dec first dout", vdata[0], 24'h2A2B00);
    end

    // Reset while valid is high: valid must drop at once
    hold_reset(2);
    release_rst();
    repeat (R + 1) tick();
    check_eq("out valid high", valid, 1);
    reset = 1'b0;
    #1;
    check_eq("out rst valid", valid, 0);
    check_eq("out rst dout", dout, 0);
    hold_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
